// File: rtl/dcache_wbuf_pkg.sv
// Shared types and constants for the data-cache posted-write-buffer front end.
package dcache_wbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RQ   = 2'd1,
    ST_WAIT = 2'd2,
    ST_FWD  = 2'd3
  } state_t;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] WR_TYPE_WORD = 3'b010;

  localparam int WORD_W = 30;
  localparam int STRB_W = 4;
  localparam int WDAT_W = 32;

  localparam logic [STRB_W-1:0] STRB_FULL = 4'hF;

  // Word index back to a word-aligned byte address.
  function automatic logic [31:0] word_to_addr(input logic [WORD_W-1:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_wbuf_fifo.sv
// Posted-write FIFO with combinational conflict and youngest-match lookup.
module wbuf_fifo
  import dcache_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_word,
  input  logic [STRB_W-1:0] push_strb,
  input  logic [WDAT_W-1:0] push_data,
  input  logic              pop,
  input  logic [WORD_W-1:0] look_word,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head_word,
  output logic [STRB_W-1:0] head_strb,
  output logic [WDAT_W-1:0] head_data,
  output logic              match_any,
  output logic              young_valid,
  output logic [STRB_W-1:0] young_strb,
  output logic [WDAT_W-1:0] young_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic [PW:0]       count;
  logic [WORD_W-1:0] word_q [DEPTH];
  logic [STRB_W-1:0] strb_q [DEPTH];
  logic [WDAT_W-1:0] data_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_word = word_q[head_ptr];
  assign head_strb = strb_q[head_ptr];
  assign head_data = data_q[head_ptr];

  // Pointer and occupancy bookkeeping; push+pop keeps count and moves both pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + 1'b1;
      if (do_pop)  head_ptr <= head_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; validity is carried by the pointers, so no reset here.
  always_ff @(posedge clock) begin
    if (do_push) begin
      word_q[tail_ptr] <= push_word;
      strb_q[tail_ptr] <= push_strb;
      data_q[tail_ptr] <= push_data;
    end
  end

  // Walk valid entries oldest to youngest; the last hit wins as the youngest match.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    match_any   = 1'b0;
    young_valid = 1'b0;
    young_strb  = '0;
    young_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (word_q[idx] == look_word)) begin
        match_any   = 1'b1;
        young_valid = 1'b1;
        young_strb  = strb_q[idx];
        young_data  = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/dcache_wbuf.sv
// Data-cache front end: posted-write buffer draining to the bridge, plus a load FSM
// that bypasses non-conflicting stores and forwards from full-word buffered stores.
module dcache_wbuf
  import dcache_wbuf_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int FWD_EN   = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          valid,
  output logic          ready,
  input  logic          op,
  input  logic [31:0]   addr,
  input  logic          uncached,
  output logic          rvalid,
  output logic [31:0]   rdata,
  output logic          rhit,
  input  logic [3:0]    awstrb,
  input  logic [31:0]   wdata,
  output logic          whit,
  input  logic          cacop_en,
  input  logic [1:0]    cacop_code,
  input  logic [31:0]   cacop_addr,
  output logic          rd_req,
  output logic [2:0]    rd_type,
  output logic [31:0]   rd_addr,
  input  logic          rd_rdy,
  input  logic          ret_valid,
  input  logic          ret_last,
  input  logic [31:0]   ret_data,
  output logic          wr_req,
  output logic [2:0]    wr_type,
  output logic [31:0]   wr_addr,
  output logic [3:0]    wr_wstrb,
  output logic [127:0]  wr_data,
  input  logic          wr_rdy
);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] lat_word;
  logic              lat_uncached;
  logic [WDAT_W-1:0] lat_data;
  logic [WORD_W-1:0] look_word;
  logic              full;
  logic              empty;
  logic              pop;
  logic              match_any;
  logic              young_valid;
  logic [STRB_W-1:0] young_strb;
  logic [WDAT_W-1:0] young_data;
  logic [WORD_W-1:0] head_word;
  logic [STRB_W-1:0] head_strb;
  logic [WDAT_W-1:0] head_data;
  logic              load_acc;
  logic              fwd_take;
  logic              unused_ok;

  assign unused_ok = ^{cacop_code, cacop_addr, addr[1:0]};

  assign whit     = valid && ready && op && !cacop_en;
  assign load_acc = valid && ready && !op && !cacop_en;
  assign pop      = wr_req && wr_rdy;
  assign look_word = (state == ST_IDLE) ? addr[31:2] : lat_word;
  assign fwd_take  = (FWD_EN != 0) && young_valid && (young_strb == STRB_FULL);

  wbuf_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (whit),
    .push_word   (addr[31:2]),
    .push_strb   (awstrb),
    .push_data   (wdata),
    .pop         (pop),
    .look_word   (look_word),
    .full        (full),
    .empty       (empty),
    .head_word   (head_word),
    .head_strb   (head_strb),
    .head_data   (head_data),
    .match_any   (match_any),
    .young_valid (young_valid),
    .young_strb  (young_strb),
    .young_data  (young_data)
  );

  // Drain side runs independently of the load FSM; fields are gated when idle.
  always_comb begin
    wr_req   = !empty;
    wr_type  = wr_req ? WR_TYPE_WORD : 3'b000;
    wr_addr  = wr_req ? word_to_addr(head_word) : 32'h0;
    wr_wstrb = wr_req ? head_strb : 4'h0;
    wr_data  = wr_req ? {96'h0, head_data} : 128'h0;
  end

  // Request acceptance: stores need room, cache ops need an empty buffer, loads always go.
  always_comb begin
    ready = 1'b0;
    if (state == ST_IDLE) begin
      if (cacop_en)  ready = empty;
      else if (op)   ready = !full;
      else           ready = 1'b1;
    end
  end

  // Load FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Load request context captured at accept time.
  always_ff @(posedge clock) begin
    if (load_acc) begin
      lat_word     <= addr[31:2];
      lat_uncached <= uncached;
      lat_data     <= young_data;
    end
  end

  // Load FSM next state and read-side outputs.
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    rvalid    = 1'b0;
    rhit      = 1'b0;
    rdata     = 32'h0;
    case (state)
      ST_IDLE: begin
        if (load_acc) state_nxt = fwd_take ? ST_FWD : ST_RQ;
      end
      ST_RQ: begin
        rd_req = !match_any && (!lat_uncached || empty);
        if (rd_req && rd_rdy) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (ret_valid && ret_last) begin
          rvalid    = 1'b1;
          rdata     = ret_data;
          state_nxt = ST_IDLE;
        end
      end
      ST_FWD: begin
        rvalid    = 1'b1;
        rhit      = 1'b1;
        rdata     = lat_data;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_type = rd_req ? RD_TYPE_WORD : 3'b000;
  assign rd_addr = rd_req ? word_to_addr(lat_word) : 32'h0;

endmodule
